pipe_stage_chain: RTL

- Parametrised chain of STAGES pipeline registers, each carrying {valid, pc, instr}. Generalises the fixed four-register IF->ID->EXE->MEM->WB chain in the core.
- Adds per-stage valid bits, stall with bubble insertion at a selectable stage, per-stage flush, an input-ready handshake, and retire/bubble statistics counters.
- Sits between instruction fetch and the stage datapaths. Stage k output feeds datapath stage k.

---
 rtl/pipe_pkg.sv | 36 +++
 rtl/pipe_stage_reg.sv | 28 ++
 rtl/pipe_stage_chain.sv | 93 +++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage chain: the stage word layout, the all-zero bubble,
// and the per-stage control decode used by every stage register.
package pipe_pkg;

    localparam int PIPE_DATA_W = 32;

    // Default-width view of a stage word; stage registers carry the same {valid, pc, instr} packing.
    typedef struct packed {
        logic                   valid;
        logic [PIPE_DATA_W-1:0] pc;
        logic [PIPE_DATA_W-1:0] instr;
    } stage_t;

    localparam stage_t BUBBLE = '0;

    typedef enum logic [1:0] {
        HOLD,
        LOAD_PREV,
        LOAD_BUBBLE
    } stage_ctl_e;

    // Priority per stage: flush, then hold at or below the stall point, then the inserted bubble.
    function automatic stage_ctl_e stage_ctl(input int i, input logic stallEn, input int s,
                                             input logic flush);
        stage_ctl_e ctl;
        ctl = LOAD_PREV;
        if (flush)
            ctl = LOAD_BUBBLE;
        else if (stallEn && (i <= s))
            ctl = HOLD;
        else if (stallEn && (i == s + 1))
            ctl = LOAD_BUBBLE;
        return ctl;
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage register holding a {valid, pc, instr} word; it holds, takes the
// previous stage, or takes a bubble according to its control input.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  stage_ctl_e          ctl,
    input  logic [2*DATA_W:0]   prevStage,
    input  logic [2*DATA_W:0]   bubbleStage,
    output logic [2*DATA_W:0]   stageQ
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stageQ <= '0;
        end else begin
            case (ctl)
                LOAD_PREV:   stageQ <= prevStage;
                LOAD_BUBBLE: stageQ <= bubbleStage;
                default:     stageQ <= stageQ;
            endcase
        end
    end

endmodule

// File: rtl/pipe_stage_chain.sv
// Parametrised chain of pipeline registers between fetch and the stage datapaths, with
// stall/bubble insertion, per-stage flush, input-ready, and retire/bubble statistics.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int STAGES = 4,
    parameter int CNT_W  = 32,
    localparam int IDX_W = $clog2(STAGES)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_pc,
    input  logic [DATA_W-1:0]          in_instr,
    output logic                       in_ready,
    input  logic                       stall_en,
    input  logic [IDX_W-1:0]           stall_idx,
    input  logic [STAGES-1:0]          flush_mask,
    output logic [STAGES-1:0]          out_valid,
    output logic [STAGES*DATA_W-1:0]   out_pc,
    output logic [STAGES*DATA_W-1:0]   out_instr,
    output logic [CNT_W-1:0]           retire_cnt,
    output logic [CNT_W-1:0]           bubble_cnt
);

    localparam int STAGE_W = 2 * DATA_W + 1;
    localparam logic [STAGE_W-1:0] BUBBLE_WORD = '0;
    localparam logic [CNT_W-1:0]   CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [STAGE_W-1:0] stageQ [STAGES];
    logic [STAGE_W-1:0] inWord;
    stage_ctl_e         ctl [STAGES];
    int                 sEff;
    logic               bubbleInc;
    logic               retireInc;

    assign in_ready = ~stall_en;

    // A word without in_valid enters as a clean bubble so pc/instr never leak through.
    assign inWord = in_valid ? {1'b1, in_pc, in_instr} : BUBBLE_WORD;

    always_comb begin
        sEff      = (int'(stall_idx) > STAGES - 1) ? STAGES - 1 : int'(stall_idx);
        bubbleInc = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            ctl[i] = stage_ctl(i, stall_en, sEff, flush_mask[i]);
            if (stall_en && !flush_mask[i] && (i == sEff + 1))
                bubbleInc = 1'b1;
        end
    end

    assign retireInc = stageQ[STAGES-1][STAGE_W-1] && (ctl[STAGES-1] != HOLD);

    for (genvar g = 0; g < STAGES; g++) begin : gStage
        logic [STAGE_W-1:0] prevStage;

        if (g == 0) begin : gFirst
            assign prevStage = inWord;
        end else begin : gRest
            assign prevStage = stageQ[g-1];
        end

        pipe_stage_reg #(
            .DATA_W (DATA_W)
        ) uStage (
            .clk         (clk),
            .rst         (rst),
            .ctl         (ctl[g]),
            .prevStage   (prevStage),
            .bubbleStage (BUBBLE_WORD),
            .stageQ      (stageQ[g])
        );

        assign out_valid[g]                  = stageQ[g][STAGE_W-1];
        assign out_pc[g*DATA_W +: DATA_W]    = stageQ[g][2*DATA_W-1:DATA_W];
        assign out_instr[g*DATA_W +: DATA_W] = stageQ[g][DATA_W-1:0];
    end

    // Both counters wrap freely at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt <= '0;
            bubble_cnt <= '0;
        end else begin
            if (retireInc)
                retire_cnt <= retire_cnt + CNT_ONE;
            if (bubbleInc)
                bubble_cnt <= bubble_cnt + CNT_ONE;
        end
    end

endmodule
